// File: rtl/z80_io_bus_front.sv
// ============================================================================
// Module      : z80_io_bus_front
// Description : Z80 I/O bus front end. Synchronises the asynchronous Z80
//               pins, filters glitches, qualifies I/O read/write cycles for
//               one address window, and emits single-cycle strobes to the
//               downstream register logic. Read data is driven back onto the
//               Z80 data bus until the CPU ends the cycle.
//               Optional macro Z80_IO_WAIT_EN: drives z80_wait_n low while a
//               read is outstanding and around each write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_io_bus_front #(
    parameter int          SYNC_STAGES   = 2,
    parameter int          FILTER_CYCLES = 3,
    parameter logic [15:0] ADDR_BASE     = 16'd12345,
    parameter logic [15:0] ADDR_MASK     = 16'hFFFF,
    parameter int          RD_TIMEOUT    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] z80_a,
    input  logic [7:0]  z80_d_in,
    output logic [7:0]  z80_d_out,
    output logic        z80_d_oe,
    input  logic        z80_rd,
    input  logic        z80_wr,
    input  logic        z80_m1,
    input  logic        z80_iorq,
    input  logic        z80_mreq,
    output logic        z80_wait_n,
    output logic [15:0] io_addr,
    output logic [7:0]  io_wdata,
    output logic        io_wr_stb,
    output logic        io_rd_stb,
    input  logic [7:0]  io_rdata,
    input  logic        io_rd_ack
);

    // Pin bundle layout: {a[15:0], d[7:0], rd, wr, m1, iorq, mreq}
    localparam int          c_PW       = 29;
    localparam logic [28:0] c_PIN_IDLE = {16'h0000, 8'h00, 5'b11111};
    localparam int          c_TW       = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUALIFY = 3'd1,
        S_RD_WAIT = 3'd2,
        S_HOLD    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    logic [c_PW-1:0]                   w_pins;
    logic [SYNC_STAGES-1:0][c_PW-1:0]  r_sync;
    logic [c_PW-1:0]                   w_s;
    logic [15:0]                       s_a;
    logic [7:0]                        s_d;
    logic                              s_rd, s_wr, s_m1, s_iorq, s_mreq;
    logic                              w_match, w_same;

    state_t          r_state, w_state_nx;
    logic [3:0]      r_fcnt, w_fcnt_nx;
    logic [4:0]      w_fcnt_inc;
    logic            r_kind_rd, w_kind_nx;
    logic [15:0]     r_qaddr, w_qaddr_nx;
    logic [c_TW-1:0] r_tcnt, w_tcnt_nx;
    logic [7:0]      r_d_out, w_d_out_nx;
    logic            r_d_oe, w_d_oe_nx;
    logic [15:0]     r_io_addr, w_addr_nx;
    logic [7:0]      r_io_wdata, w_wdata_nx;
    logic            r_wr_stb, w_wr_stb_nx;
    logic            r_rd_stb, w_rd_stb_nx;

    assign w_pins = {z80_a, z80_d_in, z80_rd, z80_wr, z80_m1, z80_iorq, z80_mreq};

    // Synchroniser chain shared by every pin so address, data and control stay aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{c_PIN_IDLE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_pins};
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign s_a    = w_s[28:13];
    assign s_d    = w_s[12:5];
    assign s_rd   = w_s[4];
    assign s_wr   = w_s[3];
    assign s_m1   = w_s[2];
    assign s_iorq = w_s[1];
    assign s_mreq = w_s[0];

    // I/O cycle to our window: excludes interrupt acknowledge and rd+wr together
    assign w_match = !s_iorq && s_mreq && s_m1 && (s_rd ^ s_wr) &&
                     ((s_a & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
    assign w_same  = w_match && ((!s_rd) == r_kind_rd) && (s_a == r_qaddr);

    // Next-state and next-output decode for the bus-cycle FSM
    always_comb begin
        w_state_nx  = r_state;
        w_fcnt_nx   = r_fcnt;
        w_kind_nx   = r_kind_rd;
        w_qaddr_nx  = r_qaddr;
        w_tcnt_nx   = r_tcnt;
        w_d_out_nx  = r_d_out;
        w_d_oe_nx   = r_d_oe;
        w_addr_nx   = r_io_addr;
        w_wdata_nx  = r_io_wdata;
        w_wr_stb_nx = 1'b0;
        w_rd_stb_nx = 1'b0;
        w_fcnt_inc  = {1'b0, r_fcnt} + 5'd1;

        case (r_state)
            S_IDLE: begin
                if (w_match) begin
                    w_fcnt_nx  = 4'd1;
                    w_kind_nx  = !s_rd;
                    w_qaddr_nx = s_a;
                    w_state_nx = S_QUALIFY;
                end
            end
            S_QUALIFY: begin
                if (w_same) begin
                    if (w_fcnt_inc >= 5'(FILTER_CYCLES)) begin
                        w_fcnt_nx = 4'd0;
                        w_addr_nx = s_a;
                        if (r_kind_rd) begin
                            w_rd_stb_nx = 1'b1;
                            w_d_oe_nx   = 1'b1;
                            w_tcnt_nx   = '0;
                            w_state_nx  = S_RD_WAIT;
                        end else begin
                            w_wdata_nx  = s_d;
                            w_wr_stb_nx = 1'b1;
                            w_state_nx  = S_RELEASE;
                        end
                    end else begin
                        w_fcnt_nx = w_fcnt_inc[3:0];
                    end
                end else begin
                    w_fcnt_nx  = 4'd0;
                    w_state_nx = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                // CPU abandoning the cycle wins over any ack arriving now
                if (s_rd || s_iorq) begin
                    w_d_oe_nx  = 1'b0;
                    w_state_nx = S_RELEASE;
                end else if (io_rd_ack) begin
                    w_d_out_nx = io_rdata;
                    w_state_nx = S_HOLD;
                end else if (r_tcnt == c_TW'(RD_TIMEOUT)) begin
                    w_d_out_nx = 8'hFF;
                    w_state_nx = S_HOLD;
                end else begin
                    w_tcnt_nx = r_tcnt + c_TW'(1);
                end
            end
            S_HOLD: begin
                if (s_rd || s_iorq) begin
                    w_d_oe_nx  = 1'b0;
                    w_state_nx = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // One strobe per bus cycle: wait for the bus to go fully idle
                if (s_rd && s_wr && s_iorq) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fcnt     <= 4'd0;
            r_kind_rd  <= 1'b0;
            r_qaddr    <= 16'h0000;
            r_tcnt     <= '0;
            r_d_out    <= 8'h00;
            r_d_oe     <= 1'b0;
            r_io_addr  <= 16'h0000;
            r_io_wdata <= 8'h00;
            r_wr_stb   <= 1'b0;
            r_rd_stb   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_fcnt     <= w_fcnt_nx;
            r_kind_rd  <= w_kind_nx;
            r_qaddr    <= w_qaddr_nx;
            r_tcnt     <= w_tcnt_nx;
            r_d_out    <= w_d_out_nx;
            r_d_oe     <= w_d_oe_nx;
            r_io_addr  <= w_addr_nx;
            r_io_wdata <= w_wdata_nx;
            r_wr_stb   <= w_wr_stb_nx;
            r_rd_stb   <= w_rd_stb_nx;
        end
    end

`ifdef Z80_IO_WAIT_EN
    logic r_wait_n, w_wait_n_nx;

    // WAIT low while a read is outstanding, and for the write strobe cycle plus one
    always_comb begin
        w_wait_n_nx = 1'b1;
        if (w_wr_stb_nx || r_wr_stb) begin
            w_wait_n_nx = 1'b0;
        end
        if (w_state_nx == S_RD_WAIT) begin
            w_wait_n_nx = 1'b0;
        end
    end

    // WAIT register, released on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_n <= 1'b1;
        end else begin
            r_wait_n <= w_wait_n_nx;
        end
    end

    assign z80_wait_n = r_wait_n;
`else
    assign z80_wait_n = 1'b1;
`endif

    assign z80_d_out = r_d_out;
    assign z80_d_oe  = r_d_oe;
    assign io_addr   = r_io_addr;
    assign io_wdata  = r_io_wdata;
    assign io_wr_stb = r_wr_stb;
    assign io_rd_stb = r_rd_stb;

endmodule

`default_nettype wire

// File: doc/z80_io_bus_front.md
Name: z80_io_bus_front

Overview:
Upstream front end for the Z80 I/O decode logic.
- Samples asynchronous Z80 bus pins into the internal 48 MHz domain and filters glitches.
- Qualifies I/O read and write cycles for one address window.
- Emits single-cycle strobes with latched address and data to the downstream register/LED logic.
- On reads, drives the Z80 data bus with the returned byte until the CPU releases the cycle.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizer on every Z80 pin (minimum 2)
FILTER_CYCLES, 3, consecutive identical synchronized samples required before a cycle is qualified (1..15)
ADDR_BASE, 16'd12345, I/O address owned by this block
ADDR_MASK, 16'hFFFF, address bits compared against ADDR_BASE
RD_TIMEOUT, 32, clk cycles to wait for io_rd_ack before returning 8'hFF

Ports:
clk  in  1  internal oscillator clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
z80_a  in  16  Z80 address bus (async)
z80_d_in  in  8  Z80 data bus input (async)
z80_d_out  out  8  data driven to Z80 on reads
z80_d_oe  out  1  data bus output enable, active high
z80_rd, z80_wr, z80_m1, z80_iorq, z80_mreq  in  1 each  Z80 control pins, active low, async
z80_wait_n  out  1  Z80 WAIT request, active low
io_addr  out  16  address latched at qualification
io_wdata  out  8  write data latched at qualification
io_wr_stb  out  1  one-clk pulse: qualified write
io_rd_stb  out  1  one-clk pulse: qualified read request
io_rdata  in  8  read data from downstream
io_rd_ack  in  1  io_rdata valid; sampled only in RD_WAIT

Behaviour:
- Reset (async assert, sync release) values: z80_d_out=0, z80_d_oe=0, z80_wait_n=1, io_addr=0, io_wdata=0, io_wr_stb=0, io_rd_stb=0. FSM enters IDLE; filter counter is 0.
- Every Z80 pin passes through SYNC_STAGES flip-flops. Address and data pins are sampled through the same chain.
- match is true when iorq=0, mreq=1, m1=1, (a & ADDR_MASK)==(ADDR_BASE & ADDR_MASK), and exactly one of rd and wr is 0. Interrupt acknowledge (iorq=0 with m1=0) never matches. rd=0 together with wr=0 never matches.
- FSM states:
  - IDLE: on match, load the filter counter with 1, latch the kind (rd or wr), and go to QUALIFY.
  - QUALIFY: each cycle, if match holds with the same kind and the same address, increment the counter. Otherwise return to IDLE. When the counter reaches FILTER_CYCLES:
    - write: latch io_addr and io_wdata, pulse io_wr_stb, go to RELEASE.
    - read: latch io_addr, pulse io_rd_stb, assert z80_d_oe, go to RD_WAIT.
  - RD_WAIT: a timeout counter starts at 0.
    - On io_rd_ack=1: z80_d_out <= io_rdata, go to HOLD.
    - If the counter reaches RD_TIMEOUT first: z80_d_out <= 8'hFF, go to HOLD.
    - If rd or iorq deasserts: drop z80_d_oe and go to RELEASE (aborted read; a late ack is ignored).
  - HOLD: keep z80_d_oe=1 and z80_d_out stable. When synchronized rd=1 or iorq=1: z80_d_oe <= 0, go to RELEASE.
  - RELEASE: wait until synchronized rd=1, wr=1, and iorq=1, then go to IDLE. One bus cycle produces at most one strobe.
- Strobes are registered, exactly one clk wide, and never asserted together.
- Latency, pin edge to strobe: SYNC_STAGES + FILTER_CYCLES clk, ±1 for sampling phase.
- z80_d_oe is high only in RD_WAIT and HOLD.
- Reset mid-cycle: outputs go to reset values immediately. After release, the FSM stays in IDLE until match is seen fresh. A Z80 cycle still in progress at release gets qualified from its remaining active time and must still meet FILTER_CYCLES.

Optional Feature:
Macro Z80_IO_WAIT_EN.
- Defined:
  - z80_wait_n is driven 0 from the io_rd_stb cycle until the cycle z80_d_out is loaded (ack or timeout); the next cycle it returns to 1.
  - z80_wait_n is also 0 for the io_wr_stb cycle plus 1 cycle.
  - It is forced to 1 on reset or on a RD_WAIT abort.
- Not defined: z80_wait_n is constant 1 and no wait logic is synthesized.

Test Plan:
- Write 8'hA5 to 12345 (iorq=0, wr=0 for 10 clk): exactly one io_wr_stb with io_addr=12345 and io_wdata=8'hA5; z80_d_oe stays 0.
- Read 12345, io_rd_ack=1 with io_rdata=8'h3C 4 clk after io_rd_stb: z80_d_out=8'h3C with z80_d_oe=1 until rd rises, then z80_d_oe=0 within SYNC_STAGES+1 clk.
- Read 12345 with io_rd_ack held 0: after RD_TIMEOUT=32 clk, z80_d_out=8'hFF; with Z80_IO_WAIT_EN, z80_wait_n is low for the 33 clk from io_rd_stb through the 8'hFF load cycle.
- Glitch: iorq=0 and wr=0 pulse lasting FILTER_CYCLES-1 clk at 12345 -> no strobe. Address 12346, or m1=0 with iorq=0 -> no strobe and no d_oe.
- rst_n asserted low in HOLD: z80_d_oe=0 and z80_d_out=0 in the same cycle. After release with the bus idle, the next write to 12345 produces a normal single strobe.
- Back-to-back write then read with 2 idle clk between them: one io_wr_stb then one io_rd_stb, never overlapping.
